seven_segment_display: RTL and testbench
========================================

Name: seven_segment_display

Overview:
Time-multiplexed driver for a 5-digit seven-segment display in the parking system.
- Input s1a packs four 3-bit section counts (0-7); digits 0-3 display them.
- Digit 4 displays how many sections are full (field value 7), range 0-4.
- One digit is enabled at a time, cycling continuously at a rate set by a prescaler.

Parameters:
REFRESH_CYCLES, 4, clocks per digit slot; must be >=1. A full 5-digit scan takes 5*REFRESH_CYCLES clocks (20 clocks = 400 ns at 50 MHz by default).

Ports:
clk  input  1  system clock, rising edge, 50 MHz nominal
rst_n  input  1  asynchronous active-low reset
s1a  input  12  four packed 3-bit counts: field k = s1a[3k+2:3k], k=0..3
set_Data  output  8  segment pattern {dp,g,f,e,d,c,b,a}, active-high
see_sel  output  5  one-hot digit enable, active-high; bit k enables digit k

Behaviour:
- State:
  - prescaler counter, 0..REFRESH_CYCLES-1
  - digit index, 0..4
  - registered set_Data and see_sel
- Reset (rst_n low, asynchronous):
  - prescaler=0, index=0
  - see_sel=5'b00000, set_Data=8'h00 (all dark)
  - Held while rst_n low.
- Every rising clk edge with rst_n high:
  - see_sel <= one-hot(index)
  - set_Data <= encode(value(index))
  - If prescaler==REFRESH_CYCLES-1: prescaler<=0 and index advances (4 wraps to 0). Otherwise prescaler increments.
- Scan timing:
  - First edge after reset release shows digit 0.
  - Each digit is held exactly REFRESH_CYCLES clocks.
  - Order is 0,1,2,3,4,0,...
- Digit values:
  - value(k) = s1a[3k+2:3k] for k=0..3.
  - value(4) = number of fields equal to 3'b111 (0..4).
- Latency: s1a is sampled combinationally each clock. A change on s1a appears on set_Data one clock later, for whichever digit is currently selected. No input handshake.
- Encoding (bit 7 dp always 0):
  - 0=8'h3F, 1=8'h06, 2=8'h5B, 3=8'h4F, 4=8'h66, 5=8'h6D, 6=8'h7D, 7=8'h07.
  - Any other value: 8'h00 (unreachable).
- see_sel is exactly one-hot at all times outside reset; never zero, never multi-hot.
- Reset asserted mid-scan: immediate blank, and the scan restarts at digit 0.
- REFRESH_CYCLES=1: index advances every clock.

Optional Feature:
SEG_ACTIVE_LOW_EN
- Defined (common-anode boards): set_Data and see_sel are bitwise inverted at the output registers.
  - Reset values become set_Data=8'hFF, see_sel=5'b11111.
  - An enabled digit is 0; a lit segment is 0.
- Undefined: active-high polarity as described above.

Test Plan:
- Reset: hold rst_n=0 for 100 ns with s1a=0 -> set_Data=8'h00, see_sel=5'b00000. Release -> next edge gives see_sel=00001, set_Data=8'h3F; digit 4 shows 8'h3F (count 0).
- Mixed s1a=12'b000111010110, observed over 400 ns:
  - digit0=6 (8'h7D), digit1=2 (8'h5B), digit2=7 (8'h07), digit3=0 (8'h3F)
  - digit4=1 (8'h06)
  - each digit held 4 clocks
- All ones s1a=12'hFFF -> digits 0-3 = 8'h07; digit4 = 4 (8'h66).
- s1a=12'b101010101010 -> digits 0-3 = 2,5,2,5 (8'h5B, 8'h6D, 8'h5B, 8'h6D); digit4 = 0 (8'h3F).
- Scan integrity across 3 full scans:
  - see_sel always one-hot
  - order 00001->00010->00100->01000->10000->00001
  - each value held REFRESH_CYCLES clocks
- Mid-scan reset: assert rst_n=0 asynchronously while digit 3 is active -> outputs go to 0 without waiting for a clock edge; after release, the scan resumes from digit 0.

Source files
------------

// File: rtl/seven_segment_display.sv
// Time-multiplexed driver for the 5-digit parking display: digits 0-3 show the four
// section counts, digit 4 shows how many sections are full. Define SEG_ACTIVE_LOW_EN
// for common-anode boards (segment and digit-select outputs inverted).
module seven_segment_display #(
  parameter int REFRESH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] s1a,
  output logic [7:0]  set_Data,
  output logic [4:0]  see_sel
);

  // A 1-bit prescaler still works when REFRESH_CYCLES is 1: it simply stays at its last value.
  localparam int              PRESC_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_CYCLES - 1);
  localparam logic [2:0]      LAST_DIGIT = 3'd4;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [7:0] SEG_INV = 8'hFF;
  localparam logic [4:0] SEL_INV = 5'b11111;
`else
  localparam logic [7:0] SEG_INV = 8'h00;
  localparam logic [4:0] SEL_INV = 5'b00000;
`endif

  function automatic logic [7:0] encode(input logic [2:0] value);
    logic [7:0] seg;
    case (value)
      3'd0:    seg = 8'h3F;
      3'd1:    seg = 8'h06;
      3'd2:    seg = 8'h5B;
      3'd3:    seg = 8'h4F;
      3'd4:    seg = 8'h66;
      3'd5:    seg = 8'h6D;
      3'd6:    seg = 8'h7D;
      3'd7:    seg = 8'h07;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  logic [PRESC_W-1:0] presc;
  logic [2:0]         idx;
  logic [2:0]         full_cnt;
  logic [2:0]         digit_val;
  logic [4:0]         sel_onehot;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    full_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      if (s1a[3*k +: 3] == 3'b111) full_cnt = full_cnt + 3'd1;
    end
  end

  always_comb begin
    digit_val = '0;
    case (idx)
      3'd0:    digit_val = s1a[2:0];
      3'd1:    digit_val = s1a[5:3];
      3'd2:    digit_val = s1a[8:6];
      3'd3:    digit_val = s1a[11:9];
      3'd4:    digit_val = full_cnt;
      default: digit_val = '0;
    endcase
  end

  assign sel_onehot = 5'b00001 << idx;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      idx      <= '0;
      set_Data <= SEG_INV;
      see_sel  <= SEL_INV;
    end else begin
      set_Data <= encode(digit_val) ^ SEG_INV;
      see_sel  <= sel_onehot ^ SEL_INV;
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= (idx == LAST_DIGIT) ? 3'd0 : idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_display.sv
// Self-checking bench for seven_segment_display: table of s1a patterns with the five
// expected digit patterns, plus reset, scan-order and mid-scan-reset sequences.
module tb_seven_segment_display;

  localparam int RC = 4;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [7:0] SEG_INV = 8'hFF;
  localparam logic [4:0] SEL_INV = 5'b11111;
`else
  localparam logic [7:0] SEG_INV = 8'h00;
  localparam logic [4:0] SEL_INV = 5'b00000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] s1a = '0;
  logic [7:0]  set_Data;
  logic [4:0]  see_sel;

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_display #(.REFRESH_CYCLES(RC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s1a      (s1a),
    .set_Data (set_Data),
    .see_sel  (see_sel)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [11:0] s1a;
    logic [7:0]  exp [5];
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Polarity-neutral views of the outputs.
  function automatic logic [7:0] seg();
    return set_Data ^ SEG_INV;
  endfunction
  function automatic logic [4:0] sel();
    return see_sel ^ SEL_INV;
  endfunction

  // Wait (bounded) at falling edges until digit k is selected; failure counts as a check.
  task automatic wait_digit(input int k, output bit found);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sel() == (5'b00001 << k)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check($sformatf("timeout_digit%0d", k), {27'd0, sel()}, 32'(5'b00001 << k));
  endtask

  initial begin
    bit found;
    logic [4:0] exp_sel;

    vecs[0] = '{s1a: 12'b000_000_000_000, exp: '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};
    vecs[1] = '{s1a: 12'b000_111_010_110, exp: '{8'h7D, 8'h5B, 8'h07, 8'h3F, 8'h06}};
    vecs[2] = '{s1a: 12'hFFF,             exp: '{8'h07, 8'h07, 8'h07, 8'h07, 8'h66}};
    vecs[3] = '{s1a: 12'b101_010_101_010, exp: '{8'h5B, 8'h6D, 8'h5B, 8'h6D, 8'h3F}};
    vecs[4] = '{s1a: 12'b011_100_001_101, exp: '{8'h6D, 8'h06, 8'h66, 8'h4F, 8'h3F}};
    vecs[5] = '{s1a: 12'b111_000_111_001, exp: '{8'h06, 8'h07, 8'h3F, 8'h07, 8'h5B}};
    vecs[6] = '{s1a: 12'b111_111_011_111, exp: '{8'h07, 8'h4F, 8'h07, 8'h07, 8'h4F}};

    // Reset held for 100 ns.
    #100;
    check("reset_set_Data", {24'd0, set_Data}, {24'd0, SEG_INV});
    check("reset_see_sel",  {27'd0, see_sel},  {27'd0, SEL_INV});
    @(negedge clk);
    check("reset_held_set_Data", {24'd0, set_Data}, {24'd0, SEG_INV});
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_sel", {27'd0, sel()}, 32'h01);
    check("first_edge_seg", {24'd0, seg()}, 32'h3F);

    // Table-driven digit values.
    foreach (vecs[v]) begin
      s1a = vecs[v].s1a;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        wait_digit(k, found);
        if (found)
          check($sformatf("vec%0d_digit%0d", v, k), {24'd0, seg()}, {24'd0, vecs[v].exp[k]});
      end
    end

    // Scan integrity over 3 full scans, starting at the first clock of digit 0.
    s1a = 12'b000_111_010_110;
    wait_digit(4, found);
    wait_digit(0, found);
    for (int i = 0; i < 15 * RC; i++) begin
      exp_sel = 5'b00001 << ((i / RC) % 5);
      check($sformatf("scan_onehot_%0d", i), {31'd0, $onehot(sel())}, 32'd1);
      check($sformatf("scan_sel_%0d", i), {27'd0, sel()}, {27'd0, exp_sel});
      @(negedge clk);
    end

    // Mid-scan asynchronous reset while digit 3 is active.
    wait_digit(3, found);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_set_Data", {24'd0, set_Data}, {24'd0, SEG_INV});
    check("midreset_see_sel",  {27'd0, see_sel},  {27'd0, SEL_INV});
    @(negedge clk);
    @(negedge clk);
    check("midreset_held_sel", {27'd0, see_sel}, {27'd0, SEL_INV});
    rst_n = 1'b1;
    for (int i = 0; i < RC; i++) begin
      @(negedge clk);
      check($sformatf("restart_digit0_sel_%0d", i), {27'd0, sel()}, 32'h01);
      check($sformatf("restart_digit0_seg_%0d", i), {24'd0, seg()}, 32'h7D);
    end
    @(negedge clk);
    check("restart_digit1_sel", {27'd0, sel()}, 32'h02);
    check("restart_digit1_seg", {24'd0, seg()}, 32'h5B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
